// File: rtl/id_exe_stage_reg.sv
// ID->EXE pipeline register: one-cycle stage with bubble insertion, flush and freeze.
// Define ID_EXE_PERF_EN to add saturating bubble/flush event counters.
module id_exe_stage_reg #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              freeze,
   input  logic              flush,
   input  logic              hazard,
   input  logic              valid_in,
   input  logic              WB_EN_in,
   input  logic              MEM_R_EN_in,
   input  logic              MEM_W_EN_in,
   input  logic              B_in,
   input  logic              S_in,
   input  logic [3:0]        EXE_CMD_in,
   input  logic [DATA_W-1:0] PC_in,
   input  logic [DATA_W-1:0] Val_Rn_in,
   input  logic [DATA_W-1:0] Val_Rm_in,
   input  logic              imm_in,
   input  logic [11:0]       shift_operand_in,
   input  logic [23:0]       simm24_in,
   input  logic [3:0]        dest_in,
   input  logic [3:0]        SR_in,
   output logic              WB_EN_out,
   output logic              MEM_R_EN_out,
   output logic              MEM_W_EN_out,
   output logic              B_out,
   output logic              S_out,
   output logic [3:0]        EXE_CMD_out,
   output logic [DATA_W-1:0] PC_out,
   output logic [DATA_W-1:0] Val_Rn_out,
   output logic [DATA_W-1:0] Val_Rm_out,
   output logic              imm_out,
   output logic [11:0]       shift_operand_out,
   output logic [23:0]       simm24_out,
   output logic [3:0]        dest_out,
   output logic [3:0]        SR_out,
   output logic              valid_out
`ifdef ID_EXE_PERF_EN
  ,output logic [CNT_W-1:0]  bubble_count,
   output logic [CNT_W-1:0]  flush_count
`endif
);

   // A bubble, a flush and an invalid ID slot all present a side-effect-free NOP to EXE.
   logic kill;

   always_comb begin
      kill = flush | hazard | ~valid_in;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         WB_EN_out         <= 1'b0;
         MEM_R_EN_out      <= 1'b0;
         MEM_W_EN_out      <= 1'b0;
         B_out             <= 1'b0;
         S_out             <= 1'b0;
         EXE_CMD_out       <= '0;
         PC_out            <= '0;
         Val_Rn_out        <= '0;
         Val_Rm_out        <= '0;
         imm_out           <= 1'b0;
         shift_operand_out <= '0;
         simm24_out        <= '0;
         dest_out          <= '0;
         SR_out            <= '0;
         valid_out         <= 1'b0;
      end else if (!freeze) begin
         WB_EN_out         <= WB_EN_in    & ~kill;
         MEM_R_EN_out      <= MEM_R_EN_in & ~kill;
         MEM_W_EN_out      <= MEM_W_EN_in & ~kill;
         B_out             <= B_in        & ~kill;
         S_out             <= S_in        & ~kill;
         EXE_CMD_out       <= kill ? 4'd0 : EXE_CMD_in;
         valid_out         <= ~kill;
         // Datapath fields load unconditionally; they are don't-care when valid_out=0.
         PC_out            <= PC_in;
         Val_Rn_out        <= Val_Rn_in;
         Val_Rm_out        <= Val_Rm_in;
         imm_out           <= imm_in;
         shift_operand_out <= shift_operand_in;
         simm24_out        <= simm24_in;
         dest_out          <= dest_in;
         SR_out            <= SR_in;
      end
   end

`ifdef ID_EXE_PERF_EN
   always_ff @(posedge clk) begin
      if (!rst) begin
         bubble_count <= '0;
         flush_count  <= '0;
      end else if (!freeze) begin
         // Flush outranks hazard, so a cycle with both counts only as a flush.
         if (flush) begin
            if (flush_count != '1) flush_count <= flush_count + 1'b1;
         end else if (hazard) begin
            if (bubble_count != '1) bubble_count <= bubble_count + 1'b1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_id_exe_stage_reg.sv
// Self-checking bench for id_exe_stage_reg: directed scenarios plus randomized traffic
// checked against a rule-level reference model.
module tb_id_exe_stage_reg;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned CNT_W  = 4;
   localparam int          SAT    = (1 << CNT_W) - 1;

   typedef struct packed {
      logic        valid;
      logic        wb;
      logic        mr;
      logic        mw;
      logic        b;
      logic        s;
      logic [3:0]  cmd;
      logic [31:0] pc;
      logic [31:0] rn;
      logic [31:0] rm;
      logic        imm;
      logic [11:0] shift;
      logic [23:0] simm;
      logic [3:0]  dest;
      logic [3:0]  sr;
   } slot_t;

   logic  clk = 1'b0;
   logic  rst, freeze, flush, hazard;
   slot_t din;
   slot_t obs;
   slot_t exp_st;
   int    checks = 0;
   int    errors = 0;
   int    bub_ev = 0;
   int    fl_ev  = 0;

   logic              wb_o, mr_o, mw_o, b_o, s_o, imm_o, valid_o;
   logic [3:0]        cmd_o, dest_o, sr_o;
   logic [DATA_W-1:0] pc_o, rn_o, rm_o;
   logic [11:0]       shift_o;
   logic [23:0]       simm_o;
`ifdef ID_EXE_PERF_EN
   logic [CNT_W-1:0]  bubble_count, flush_count;
`endif

   always #5 clk = ~clk;

   id_exe_stage_reg #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .freeze(freeze), .flush(flush), .hazard(hazard),
      .valid_in(din.valid), .WB_EN_in(din.wb), .MEM_R_EN_in(din.mr), .MEM_W_EN_in(din.mw),
      .B_in(din.b), .S_in(din.s), .EXE_CMD_in(din.cmd), .PC_in(din.pc),
      .Val_Rn_in(din.rn), .Val_Rm_in(din.rm), .imm_in(din.imm),
      .shift_operand_in(din.shift), .simm24_in(din.simm), .dest_in(din.dest), .SR_in(din.sr),
      .WB_EN_out(wb_o), .MEM_R_EN_out(mr_o), .MEM_W_EN_out(mw_o), .B_out(b_o), .S_out(s_o),
      .EXE_CMD_out(cmd_o), .PC_out(pc_o), .Val_Rn_out(rn_o), .Val_Rm_out(rm_o),
      .imm_out(imm_o), .shift_operand_out(shift_o), .simm24_out(simm_o),
      .dest_out(dest_o), .SR_out(sr_o), .valid_out(valid_o)
`ifdef ID_EXE_PERF_EN
     ,.bubble_count(bubble_count), .flush_count(flush_count)
`endif
   );

   assign obs = {valid_o, wb_o, mr_o, mw_o, b_o, s_o, cmd_o, pc_o, rn_o, rm_o,
                 imm_o, shift_o, simm_o, dest_o, sr_o};

   // Reference: what EXE should see after the next edge, stated as the pipeline rules.
   function automatic slot_t model_next(slot_t cur, slot_t d);
      slot_t r;
      if (!rst) return '0;
      if (freeze) return cur;
      r = d;
      if (!(d.valid && !flush && !hazard)) begin
         r.valid = 1'b0;
         r.wb = 1'b0; r.mr = 1'b0; r.mw = 1'b0; r.b = 1'b0; r.s = 1'b0;
         r.cmd = 4'd0;
      end
      return r;
   endfunction

   function automatic int sat(int n);
      return (n > SAT) ? SAT : n;
   endfunction

   task automatic tick();
      slot_t nxt;
      nxt = model_next(exp_st, din);
      if (!rst) begin
         bub_ev = 0; fl_ev = 0;
      end else if (!freeze) begin
         if (flush) fl_ev++;
         else if (hazard) bub_ev++;
      end
      @(posedge clk);
      #1;
      exp_st = nxt;
   endtask

   task automatic idle_inputs();
      rst = 1'b1; freeze = 1'b0; flush = 1'b0; hazard = 1'b0; din = '0;
   endtask

   task automatic test_reset();
      rst = 1'b0; freeze = 1'b1; flush = 1'b1; hazard = 1'b1; din = '1;
      tick();
      tick();
      checks++;
      if (obs !== '0) begin
         errors++; $display("FAIL reset_outputs: got %h expected 0", obs);
      end
      checks++;
      if (valid_o !== 1'b0) begin
         errors++; $display("FAIL reset_valid: got %b expected 0", valid_o);
      end
`ifdef ID_EXE_PERF_EN
      checks++;
      if (bubble_count !== '0 || flush_count !== '0) begin
         errors++; $display("FAIL reset_counters: got %0d/%0d expected 0/0", bubble_count, flush_count);
      end
`endif
   endtask

   task automatic test_load();
      idle_inputs();
      din.valid = 1'b1; din.wb = 1'b1; din.cmd = 4'd2; din.pc = 32'h10; din.dest = 4'd3;
      tick();
      checks++;
      if (wb_o !== 1'b1 || cmd_o !== 4'd2 || pc_o !== 32'h10 || dest_o !== 4'd3 || valid_o !== 1'b1) begin
         errors++;
         $display("FAIL load_add: got wb=%b cmd=%0d pc=%h dest=%0d valid=%b expected 1 2 10 3 1",
                  wb_o, cmd_o, pc_o, dest_o, valid_o);
      end
      checks++;
      if (obs !== exp_st) begin
         errors++; $display("FAIL load_model: got %h expected %h", obs, exp_st);
      end
   endtask

   task automatic test_freeze();
      slot_t held;
      held = obs;
      freeze = 1'b1;
      for (int i = 0; i < 3; i++) begin
         din = '0; din.valid = 1'b1; din.mw = 1'b1; din.cmd = 4'd4;
         din.pc = 32'h14 + 32'(i); din.dest = 4'd5;
         flush = (i == 1); hazard = (i == 2);
         tick();
         checks++;
         if (obs !== held || obs !== exp_st) begin
            errors++; $display("FAIL freeze_hold[%0d]: got %h expected %h", i, obs, held);
         end
      end
      freeze = 1'b0; flush = 1'b0; hazard = 1'b0;
      tick();
      checks++;
      if (mw_o !== 1'b1 || wb_o !== 1'b0 || valid_o !== 1'b1 || pc_o !== 32'h16) begin
         errors++;
         $display("FAIL freeze_release: got mw=%b wb=%b valid=%b pc=%h expected 1 0 1 16",
                  mw_o, wb_o, valid_o, pc_o);
      end
   endtask

   task automatic test_flush();
      slot_t held;
      idle_inputs();
      din.valid = 1'b1; din.mr = 1'b1; din.wb = 1'b1; din.cmd = 4'd2; din.pc = 32'h40; din.dest = 4'd7;
      flush = 1'b1; hazard = 1'b1;
      tick();
      checks++;
      if (valid_o !== 1'b0 || mr_o !== 1'b0 || wb_o !== 1'b0 || cmd_o !== 4'd0) begin
         errors++;
         $display("FAIL flush_bubble: got valid=%b mr=%b wb=%b cmd=%0d expected 0 0 0 0",
                  valid_o, mr_o, wb_o, cmd_o);
      end
      checks++;
      if (obs !== exp_st) begin
         errors++; $display("FAIL flush_model: got %h expected %h", obs, exp_st);
      end
      flush = 1'b0; hazard = 1'b0;
      tick();
      held = obs;
      freeze = 1'b1; flush = 1'b1; hazard = 1'b1; din.pc = 32'h99;
      tick();
      checks++;
      if (obs !== held) begin
         errors++; $display("FAIL flush_frozen: got %h expected %h", obs, held);
      end
   endtask

   task automatic test_hazard();
      idle_inputs();
      din.valid = 1'b1; din.s = 1'b1; din.cmd = 4'd4; din.pc = 32'h80;
      hazard = 1'b1;
      tick();
      checks++;
      if (s_o !== 1'b0 || valid_o !== 1'b0 || cmd_o !== 4'd0) begin
         errors++; $display("FAIL hazard_bubble: got s=%b valid=%b cmd=%0d expected 0 0 0", s_o, valid_o, cmd_o);
      end
      hazard = 1'b0;
      tick();
      checks++;
      if (s_o !== 1'b1 || valid_o !== 1'b1 || cmd_o !== 4'd4 || pc_o !== 32'h80) begin
         errors++;
         $display("FAIL hazard_reload: got s=%b valid=%b cmd=%0d pc=%h expected 1 1 4 80", s_o, valid_o, cmd_o, pc_o);
      end
      din.valid = 1'b0;
      tick();
      checks++;
      if (s_o !== 1'b0 || cmd_o !== 4'd0 || valid_o !== 1'b0) begin
         errors++; $display("FAIL invalid_slot: got s=%b cmd=%0d valid=%b expected 0 0 0", s_o, cmd_o, valid_o);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 300; i++) begin
         rst    = ($urandom_range(0, 31) != 0);
         freeze = ($urandom_range(0, 3) == 0);
         flush  = ($urandom_range(0, 7) == 0);
         hazard = ($urandom_range(0, 5) == 0);
         din    = {$urandom, $urandom, $urandom, $urandom, $urandom};
         tick();
         checks++;
         if (obs !== exp_st) begin
            errors++; $display("FAIL random[%0d]: got %h expected %h", i, obs, exp_st);
         end
         checks++;
         if (!valid_o && (wb_o || mr_o || mw_o || b_o || s_o)) begin
            errors++; $display("FAIL invariant[%0d]: got ctl=%b%b%b%b%b expected 00000 with valid=0",
                               i, wb_o, mr_o, mw_o, b_o, s_o);
         end
`ifdef ID_EXE_PERF_EN
         checks++;
         if (bubble_count !== CNT_W'(sat(bub_ev)) || flush_count !== CNT_W'(sat(fl_ev))) begin
            errors++; $display("FAIL random_counters[%0d]: got %0d/%0d expected %0d/%0d",
                               i, bubble_count, flush_count, sat(bub_ev), sat(fl_ev));
         end
`endif
      end
   endtask

`ifdef ID_EXE_PERF_EN
   task automatic test_perf();
      idle_inputs();
      rst = 1'b0;
      tick();
      rst = 1'b1; hazard = 1'b1;
      for (int i = 0; i < 20; i++) tick();
      checks++;
      if (bubble_count !== 4'd15) begin
         errors++; $display("FAIL perf_bubble_sat: got %0d expected 15", bubble_count);
      end
      hazard = 1'b0; freeze = 1'b1; flush = 1'b1;
      tick();
      tick();
      checks++;
      if (flush_count !== 4'd0 || bubble_count !== 4'd15) begin
         errors++; $display("FAIL perf_frozen_flush: got %0d/%0d expected 15/0", bubble_count, flush_count);
      end
      freeze = 1'b0; hazard = 1'b1;
      for (int i = 0; i < 17; i++) tick();
      checks++;
      if (flush_count !== 4'd15 || bubble_count !== 4'd15) begin
         errors++; $display("FAIL perf_flush_sat: got %0d/%0d expected 15/15", bubble_count, flush_count);
      end
   endtask
`endif

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete within time limit");
      $fatal(1, "timeout");
   end

   initial begin
      exp_st = '0;
      idle_inputs();
      @(posedge clk);
      #1;
      test_reset();
      test_load();
      test_freeze();
      test_flush();
      test_hazard();
      test_random();
`ifdef ID_EXE_PERF_EN
      test_perf();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
